// File: rtl/cpu_bus_seq.sv
// M-cycle bus sequencer: runs one bus op per T_PER_M T-states, stretching on mem_ready with timeout.
// Opcodes: 0 IDLE, 1 IF, 2 WRITE, 3 READ, 4 IF_CB; unlisted codes run as IDLE.
module cpu_bus_seq #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned T_PER_M  = 4,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [2:0]                 req_op,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic [2:0]                 rsp_op,
   output logic                       rsp_timeout,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_rd,
   output logic                       mem_wr,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       mem_ready,
   output logic [$clog2(T_PER_M)-1:0] t_state,
   output logic                       m_start
);

   localparam int unsigned TW = $clog2(T_PER_M);
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
   localparam logic [TW-1:0] T_DEC  = TW'(T_PER_M - 2);
   localparam logic [WW-1:0] W_LIM  = WW'(MAX_WAIT - 1);

   localparam logic [2:0] OP_IF    = 3'd1;
   localparam logic [2:0] OP_WRITE = 3'd2;
   localparam logic [2:0] OP_READ  = 3'd3;
   localparam logic [2:0] OP_IF_CB = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STRB, S_WAIT, S_LAST} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     t_q, t_d;
   logic [WW-1:0]     wait_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_rd_q, mem_wr_q;
   logic              rsp_valid_q, rsp_timeout_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [2:0]        rsp_op_q;
   logic              m_start_q;
   logic              accept, is_rd, is_wr, done, timeout;

   always_comb begin
      req_ready = (t_q == T_LAST) && ((state_q == S_IDLE) || (state_q == S_LAST));
      accept    = req_valid && req_ready;
      is_rd     = (op_q == OP_IF) || (op_q == OP_READ) || (op_q == OP_IF_CB);
      is_wr     = (op_q == OP_WRITE);
      timeout   = (state_q == S_WAIT) && !mem_ready && (wait_q == W_LIM);
      state_d   = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ADDR;
         S_ADDR:  state_d = S_STRB;
         // Only ops that drive a strobe may be stretched.
         S_STRB:  if (t_q == T_DEC)
                     state_d = (mem_ready || !(is_rd || is_wr)) ? S_LAST : S_WAIT;
         S_WAIT:  if (mem_ready || (wait_q == W_LIM)) state_d = S_LAST;
         S_LAST:  state_d = accept ? S_ADDR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      done = ((state_q == S_STRB) || (state_q == S_WAIT)) && (state_d == S_LAST);
      if (state_d == S_WAIT)
         t_d = t_q;
      else
         t_d = (t_q == T_LAST) ? '0 : t_q + TW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         t_q           <= '0;
         wait_q        <= '0;
         op_q          <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_op_q      <= '0;
         m_start_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         t_q           <= t_d;
         m_start_q     <= (t_d == '0) && (state_d != S_WAIT);
         wait_q        <= ((state_q == S_WAIT) && (state_d == S_WAIT)) ? wait_q + WW'(1) : '0;
         mem_rd_q      <= ((state_d == S_STRB) || (state_d == S_WAIT)) && is_rd;
         mem_wr_q      <= ((state_d == S_STRB) || (state_d == S_WAIT)) && is_wr;
         rsp_valid_q   <= done;
         rsp_timeout_q <= done && timeout;
         if (accept) begin
            op_q        <= req_op;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
         end
         if (done) begin
            rsp_op_q <= op_q;
            if (timeout)
               rsp_rdata_q <= '1;
            else if (is_rd)
               rsp_rdata_q <= mem_rdata;
            else
               rsp_rdata_q <= '0;
         end
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_op      = rsp_op_q;
   assign rsp_timeout = rsp_timeout_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_rd      = mem_rd_q;
   assign mem_wr      = mem_wr_q;
   assign t_state     = t_q;
   assign m_start     = m_start_q;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Bench for cpu_bus_seq: default instance (4 T, 8-bit) and a 6 T, 16-bit instance checked
// every cycle against a T-state position model, plus directed latency/data expectations.
module tb_cpu_bus_seq;

   localparam logic [2:0] OP_IDLE = 3'd0, OP_IF = 3'd1, OP_WRITE = 3'd2, OP_READ = 3'd3, OP_IF_CB = 3'd4;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        req_valid [2];
   logic [2:0]  req_op    [2];
   logic [15:0] req_addr  [2];
   logic [15:0] req_wdata [2];
   logic [15:0] mem_rdata [2];
   logic        mem_ready [2] = '{1'b1, 1'b1};

   logic        req_ready_o [2];
   logic        rsp_valid_o [2];
   logic        rsp_to_o    [2];
   logic        mem_rd_o    [2];
   logic        mem_wr_o    [2];
   logic        m_start_o   [2];
   logic [2:0]  rsp_op_o    [2];
   logic [15:0] rsp_rdata_o [2];
   logic [15:0] mem_addr_o  [2];
   logic [15:0] mem_wdata_o [2];
   logic [2:0]  t_o         [2];

   logic [7:0]  a_rdata, a_wdata;
   logic [1:0]  a_t;
   logic [15:0] b_rdata, b_wdata;
   logic [2:0]  b_t;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_bus_seq u_a (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
      .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0][7:0]),
      .rsp_valid(rsp_valid_o[0]), .rsp_rdata(a_rdata), .rsp_op(rsp_op_o[0]),
      .rsp_timeout(rsp_to_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(a_wdata),
      .mem_rd(mem_rd_o[0]), .mem_wr(mem_wr_o[0]), .mem_rdata(mem_rdata[0][7:0]),
      .mem_ready(mem_ready[0]), .t_state(a_t), .m_start(m_start_o[0])
   );

   cpu_bus_seq #(.ADDR_W(16), .DATA_W(16), .T_PER_M(6), .MAX_WAIT(4)) u_b (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
      .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid_o[1]), .rsp_rdata(b_rdata), .rsp_op(rsp_op_o[1]),
      .rsp_timeout(rsp_to_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(b_wdata),
      .mem_rd(mem_rd_o[1]), .mem_wr(mem_wr_o[1]), .mem_rdata(mem_rdata[1]),
      .mem_ready(mem_ready[1]), .t_state(b_t), .m_start(m_start_o[1])
   );

   assign rsp_rdata_o[0] = {8'h00, a_rdata};
   assign mem_wdata_o[0] = {8'h00, a_wdata};
   assign t_o[0]         = {1'b0, a_t};
   assign rsp_rdata_o[1] = b_rdata;
   assign mem_wdata_o[1] = b_wdata;
   assign t_o[1]         = b_t;

   function automatic int tpm(input int i);
      return (i == 0) ? 4 : 6;
   endfunction
   function automatic int mwt(input int i);
      return (i == 0) ? 15 : 4;
   endfunction
   function automatic logic [15:0] dmask(input int i);
      return (i == 0) ? 16'h00FF : 16'hFFFF;
   endfunction
   function automatic bit op_rd(input logic [2:0] op);
      return (op == OP_IF) || (op == OP_READ) || (op == OP_IF_CB);
   endfunction
   function automatic bit op_wr(input logic [2:0] op);
      return op == OP_WRITE;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", nm, i, act, exp, $time);
      end
   endtask

   // Model: position within the M-cycle, an op in flight, and stall edges spent at T-2.
   int          mt     [2];
   int          cyc    [2];
   int          stall  [2];
   bit          active [2];
   logic [2:0]  m_op   [2];
   logic [15:0] m_addr [2];
   logic [15:0] m_wd   [2];
   logic [15:0] m_rdat [2];
   bit          m_to   [2];
   int          low_left [2] = '{0, 0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            mt[i] = 0; cyc[i] = 0; stall[i] = 0; active[i] = 0; m_op[i] = '0;
            m_addr[i] = '0; m_wd[i] = '0; m_rdat[i] = '0; m_to[i] = 0;
         end else begin
            cyc[i]++;
            if (mt[i] == tpm(i) - 1) begin
               active[i] = 0;
               if (req_valid[i]) begin
                  active[i] = 1; m_op[i] = req_op[i]; stall[i] = 0;
                  m_addr[i] = req_addr[i]; m_wd[i] = req_wdata[i] & dmask(i);
               end
               mt[i] = 0;
            end else if (active[i] && mt[i] == tpm(i) - 2 && (op_rd(m_op[i]) || op_wr(m_op[i]))
                         && !mem_ready[i] && stall[i] < mwt(i)) begin
               stall[i]++;
            end else begin
               if (active[i] && mt[i] == tpm(i) - 2) begin
                  m_to[i]   = (op_rd(m_op[i]) || op_wr(m_op[i])) && !mem_ready[i];
                  m_rdat[i] = m_to[i] ? dmask(i) : (op_rd(m_op[i]) ? (mem_rdata[i] & dmask(i)) : 16'h0000);
               end
               mt[i]++;
            end
         end
      end
   end

   // Slave: pulls mem_ready low for the requested number of cycles at T-state T-2.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (active[i] && mt[i] == tpm(i) - 2 && low_left[i] > 0) begin
            mem_ready[i] = 1'b0;
            low_left[i]--;
         end else begin
            mem_ready[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst[i]) begin
            chk("t_state",   i, t_o[i], mt[i]);
            chk("m_start",   i, m_start_o[i], (mt[i] == 0 && cyc[i] > 0));
            chk("req_ready", i, req_ready_o[i], (mt[i] == tpm(i) - 1));
            chk("rsp_valid", i, rsp_valid_o[i], (active[i] && mt[i] == tpm(i) - 1));
            chk("mem_rd",    i, mem_rd_o[i], (active[i] && op_rd(m_op[i]) && mt[i] >= 1 && mt[i] <= tpm(i) - 2));
            chk("mem_wr",    i, mem_wr_o[i], (active[i] && op_wr(m_op[i]) && mt[i] >= 1 && mt[i] <= tpm(i) - 2));
            chk("mem_addr",  i, mem_addr_o[i], m_addr[i]);
            chk("mem_wdata", i, mem_wdata_o[i], m_wd[i]);
            if (active[i] && mt[i] == tpm(i) - 1) begin
               chk("rsp_op",      i, rsp_op_o[i], m_op[i]);
               chk("rsp_rdata",   i, rsp_rdata_o[i], m_rdat[i]);
               chk("rsp_timeout", i, rsp_to_o[i], m_to[i]);
            end
         end
      end
   end

   task automatic do_op(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int nlow, output int lat,
                        output logic [15:0] rdata, output logic to, output logic rdy);
      int n;
      n = 0;
      while (mt[i] != tpm(i) - 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_valid[i] = 1'b1; req_op[i] = op; req_addr[i] = a; req_wdata[i] = wd;
      mem_rdata[i] = rd; low_left[i] = nlow;
      @(negedge clk);
      req_valid[i] = 1'b0; req_op[i] = OP_READ; req_addr[i] = ~a; req_wdata[i] = ~wd;
      lat = 1;
      while (!rsp_valid_o[i] && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata_o[i];
      to    = rsp_to_o[i];
      rdy   = req_ready_o[i];
   endtask

   initial begin
      int lat;
      int seen;
      logic [15:0] rd;
      logic to, rdy;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_op[i] = '0;
         req_addr[i] = '0; req_wdata[i] = '0; mem_rdata[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_mem_rd", 0, mem_rd_o[0], 0);
      chk("rst_rsp_valid", 0, rsp_valid_o[0], 0);
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk("rst_t_state", 0, t_o[0], 0);

      do_op(0, OP_READ, 16'hC000, 16'h0000, 16'h003E, 0, lat, rd, to, rdy);
      chk("read_lat", 0, lat, 4);
      chk("read_data", 0, rd, 16'h003E);
      chk("read_to", 0, to, 0);

      do_op(0, OP_WRITE, 16'hFF40, 16'h0091, 16'h0077, 0, lat, rd, to, rdy);
      chk("write_lat", 0, lat, 4);
      chk("write_data", 0, rd, 16'h0000);
      chk("b2b_ready", 0, rdy, 1);
      do_op(0, OP_IF, 16'h0100, 16'h0000, 16'h00A7, 0, lat, rd, to, rdy);
      chk("if_lat", 0, lat, 4);
      chk("if_data", 0, rd, 16'h00A7);

      do_op(0, OP_READ, 16'h1234, 16'h0000, 16'h005C, 3, lat, rd, to, rdy);
      chk("stretch_lat", 0, lat, 7);
      chk("stretch_data", 0, rd, 16'h005C);

      do_op(0, OP_READ, 16'h2000, 16'h0000, 16'h0011, 1000, lat, rd, to, rdy);
      chk("tmo_lat", 0, lat, 19);
      chk("tmo_data", 0, rd, 16'h00FF);
      chk("tmo_flag", 0, to, 1);

      do_op(0, OP_IDLE, 16'h3000, 16'h0000, 16'h0055, 2, lat, rd, to, rdy);
      chk("idle_lat", 0, lat, 4);
      chk("idle_data", 0, rd, 16'h0000);

      do_op(0, OP_WRITE, 16'h4000, 16'h00C3, 16'h0000, 1000, lat, rd, to, rdy);
      chk("wr_tmo_lat", 0, lat, 19);
      chk("wr_tmo_data", 0, rd, 16'h00FF);

      do_op(1, OP_IF_CB, 16'h8000, 16'h0000, 16'hBEEF, 0, lat, rd, to, rdy);
      chk("ifcb_lat", 1, lat, 6);
      chk("ifcb_data", 1, rd, 16'hBEEF);
      chk("ifcb_op", 1, rsp_op_o[1], OP_IF_CB);
      do_op(1, OP_READ, 16'h9000, 16'h0000, 16'h1234, 1000, lat, rd, to, rdy);
      chk("b_tmo_lat", 1, lat, 10);
      chk("b_tmo_data", 1, rd, 16'hFFFF);

      // Reset in the middle of a WRITE strobe.
      seen = 0;
      while (mt[0] != 3 && seen < 10) begin
         @(negedge clk);
         seen++;
      end
      req_valid[0] = 1'b1; req_op[0] = OP_WRITE; req_addr[0] = 16'h5000; req_wdata[0] = 16'h0066;
      low_left[0] = 0;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("wr_pre_rst", 0, mem_wr_o[0], 1);
      #2 rst[0] = 1'b1;
      #1;
      chk("rst_wr_drop", 0, mem_wr_o[0], 0);
      chk("rst_no_rsp", 0, rsp_valid_o[0], 0);
      @(negedge clk);
      rst[0] = 1'b0;
      chk("post_rst_t", 0, t_o[0], 0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid_o[0]) seen++;
      end
      chk("post_rst_no_rsp", 0, seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
